msrv32_lsu: RTL and testbench

Load/store unit sitting directly downstream of msrv32_decoder. It consumes the decoder's memory-request, load-size/unsigned and misalignment outputs together with the integer adder address and rs2. It runs a single-outstanding data-bus transaction with wait states and stalls the pipeline while the transaction is open. It returns aligned, sign- or zero-extended load data to the write-back mux, which selects it as WB_LU.

---
 rtl/msrv32_lsu_pkg.sv | 35 +++
 rtl/msrv32_load_align.sv | 27 ++
 rtl/msrv32_lsu.sv | 128 ++++++++++++
 tb/tb_msrv32_lsu.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/msrv32_lsu_pkg.sv
// Shared encodings for the load/store unit: FSM states, access sizes,
// the write-back select value and the registered request record.
package msrv32_lsu_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_BUSY = 2'd1,
        LSU_DONE = 2'd2
    } lsu_state_e;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // Write-back mux select for load-unit data; the decoder uses the same value.
    localparam logic [2:0] WB_LU = 3'd1;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [1:0]  off;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } lsu_req_t;

    function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    return 4'b0001 << off;
            SZ_H:    return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/msrv32_load_align.sv
// Combinational load extract/extend: picks the byte or half addressed by
// offset from a bus word and sign- or zero-extends it to 32 bits.
module msrv32_load_align
    import msrv32_lsu_pkg::*;
(
    input  logic [31:0] rdata_in,
    input  logic [1:0]  offset_in,
    input  logic [1:0]  size_in,
    input  logic        unsigned_in,
    output logic [31:0] data_out
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b        = rdata_in[{offset_in, 3'b000} +: 8];
        h        = offset_in[1] ? rdata_in[31:16] : rdata_in[15:0];
        data_out = rdata_in;
        case (size_in)
            SZ_B:    data_out = {{24{~unsigned_in & b[7]}}, b};
            SZ_H:    data_out = {{16{~unsigned_in & h[15]}}, h};
            default: data_out = rdata_in;
        endcase
    end

endmodule

// File: rtl/msrv32_lsu.sv
// Single-outstanding load/store unit with wait-state bus handshake and stall.
// Optional bus timeout: define MSRV32_LSU_TIMEOUT_EN.
module msrv32_lsu
    import msrv32_lsu_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              mem_wr_req_in,
    input  logic              mem_rd_req_in,
    input  logic [1:0]        load_size_in,
    input  logic              load_unsigned_in,
    input  logic              misaligned_load_in,
    input  logic              misaligned_store_in,
    input  logic              trap_taken_in,
    input  logic [ADDR_W-1:0] iadder_in,
    input  logic [31:0]       rs2_in,
    output logic              d_req_out,
    output logic              d_we_out,
    output logic [ADDR_W-1:0] d_addr_out,
    output logic [31:0]       d_wdata_out,
    output logic [3:0]        d_wr_mask_out,
    input  logic              d_ack_in,
    input  logic [31:0]       d_rdata_in,
    input  logic              d_err_in,
    output logic              stall_out,
    output logic [31:0]       lu_data_out,
    output logic              lu_valid_out,
    output logic              access_fault_out
);

    lsu_state_e        state, state_nxt;
    lsu_req_t          req, req_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       aligned;
    logic              issue, timeout, busy_ack;

    assign issue = (mem_rd_req_in | mem_wr_req_in)
                 & ~((mem_rd_req_in & misaligned_load_in) | (mem_wr_req_in & misaligned_store_in))
                 & ~trap_taken_in;
    assign busy_ack = (state == LSU_BUSY) & d_ack_in;

`ifdef MSRV32_LSU_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt;

    // Held at zero while idle, so it starts from zero on every BUSY entry.
    always_ff @(posedge clk_in) begin
        if (rst_in || state != LSU_BUSY) cnt <= '0;
        else if (!d_ack_in)              cnt <= cnt + 1'b1;
    end

    assign timeout = (state == LSU_BUSY) & ~d_ack_in & (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        req_nxt       = '0;
        req_nxt.we    = mem_wr_req_in;
        req_nxt.size  = load_size_in;
        req_nxt.uns   = load_unsigned_in;
        req_nxt.off   = iadder_in[1:0];
        req_nxt.mask  = mem_wr_req_in ? store_mask(load_size_in, iadder_in[1:0]) : 4'b0000;
        case (load_size_in)
            SZ_B:    req_nxt.wdata = {4{rs2_in[7:0]}};
            SZ_H:    req_nxt.wdata = {2{rs2_in[15:0]}};
            default: req_nxt.wdata = rs2_in;
        endcase
    end

    always_comb begin
        state_nxt = state;
        stall_out = 1'b0;
        case (state)
            LSU_IDLE: begin
                stall_out = issue;
                if (issue) state_nxt = LSU_BUSY;
            end
            LSU_BUSY: begin
                stall_out = 1'b1;
                if (d_ack_in)     state_nxt = (d_err_in || req.we) ? LSU_IDLE : LSU_DONE;
                else if (timeout) state_nxt = LSU_IDLE;
            end
            LSU_DONE: begin
                stall_out = 1'b1;
                state_nxt = LSU_IDLE;
            end
            default: state_nxt = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state            <= LSU_IDLE;
            req              <= '0;
            addr_q           <= '0;
            lu_data_out      <= 32'h0;
            access_fault_out <= 1'b0;
        end else begin
            state            <= state_nxt;
            access_fault_out <= (busy_ack & d_err_in) | timeout;
            if (state == LSU_IDLE && issue) begin
                req    <= req_nxt;
                addr_q <= {iadder_in[ADDR_W-1:2], 2'b00};
            end
            if (busy_ack && !d_err_in && !req.we) lu_data_out <= aligned;
        end
    end

    msrv32_load_align u_align (
        .rdata_in    (d_rdata_in),
        .offset_in   (req.off),
        .size_in     (req.size),
        .unsigned_in (req.uns),
        .data_out    (aligned)
    );

    assign d_req_out     = (state == LSU_BUSY);
    assign lu_valid_out  = (state == LSU_DONE);
    assign d_we_out      = req.we;
    assign d_addr_out    = addr_q;
    assign d_wdata_out   = req.wdata;
    assign d_wr_mask_out = req.mask;

endmodule

// File: tb/tb_msrv32_lsu.sv
// Directed plus randomized bench for msrv32_lsu against an arithmetic model
// of load extraction, store lane replication and byte masks.
module tb_msrv32_lsu;

`ifdef MSRV32_LSU_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        mem_wr_req_in = 0, mem_rd_req_in = 0;
    logic [1:0]  load_size_in = 0;
    logic        load_unsigned_in = 0;
    logic        misaligned_load_in = 0, misaligned_store_in = 0, trap_taken_in = 0;
    logic [31:0] iadder_in = 0, rs2_in = 0;
    logic        d_req_out, d_we_out;
    logic [31:0] d_addr_out, d_wdata_out;
    logic [3:0]  d_wr_mask_out;
    logic        d_ack_in = 0, d_err_in = 0;
    logic [31:0] d_rdata_in = 0;
    logic        stall_out, lu_valid_out, access_fault_out;
    logic [31:0] lu_data_out;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    msrv32_lsu #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .mem_wr_req_in(mem_wr_req_in), .mem_rd_req_in(mem_rd_req_in),
        .load_size_in(load_size_in), .load_unsigned_in(load_unsigned_in),
        .misaligned_load_in(misaligned_load_in), .misaligned_store_in(misaligned_store_in),
        .trap_taken_in(trap_taken_in), .iadder_in(iadder_in), .rs2_in(rs2_in),
        .d_req_out(d_req_out), .d_we_out(d_we_out), .d_addr_out(d_addr_out),
        .d_wdata_out(d_wdata_out), .d_wr_mask_out(d_wr_mask_out),
        .d_ack_in(d_ack_in), .d_rdata_in(d_rdata_in), .d_err_in(d_err_in),
        .stall_out(stall_out), .lu_data_out(lu_data_out),
        .lu_valid_out(lu_valid_out), .access_fault_out(access_fault_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_load(input logic [31:0] rdata, input int off,
                                           input int size, input logic uns);
        logic [31:0] v = rdata >> (8 * off);
        if (size == 0) begin
            v = v & 32'hFF;
            if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (size == 1) begin
            v = v & 32'hFFFF;
            if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
        end else v = rdata;
        return v;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] rs2, input int size);
        if (size == 0) return (rs2 & 32'hFF) * 32'h0101_0101;
        if (size == 1) return (rs2 & 32'hFFFF) * 32'h0001_0001;
        return rs2;
    endfunction

    function automatic logic [31:0] m_mask(input int size, input int off);
        if (size == 0) return 32'(1 << off);
        if (size == 1) return 32'(3 << off);
        return 32'd15;
    endfunction

    task automatic txn(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] rs2,
                       input logic [31:0] rdata, input int waits, input logic err);
        int off = int'(addr & 3);
        @(negedge clk_in);
        mem_wr_req_in = we; mem_rd_req_in = ~we; load_size_in = sz;
        load_unsigned_in = uns; iadder_in = addr; rs2_in = rs2; d_ack_in = 0;
        #1;
        chk("issue_stall", stall_out, 1);
        chk("issue_noreq", d_req_out, 0);
        @(negedge clk_in);
        mem_wr_req_in = 0; mem_rd_req_in = 0;
        iadder_in = $urandom; rs2_in = $urandom;
        chk("bus_we", d_we_out, we);
        chk("bus_mask", d_wr_mask_out, we ? m_mask(sz, off) : 32'd0);
        if (we) chk("bus_wdata", d_wdata_out, m_wdata(rs2, sz));
        repeat (waits) begin
            chk("wait_req", d_req_out, 1);
            chk("wait_addr", d_addr_out, addr & ~32'd3);
            chk("wait_stall", stall_out, 1);
            @(negedge clk_in);
        end
        chk("ack_req", d_req_out, 1);
        chk("ack_addr", d_addr_out, addr & ~32'd3);
        d_ack_in = 1; d_rdata_in = rdata; d_err_in = err;
        @(negedge clk_in);
        d_ack_in = 0; d_err_in = 0; d_rdata_in = $urandom;
        chk("post_req", d_req_out, 0);
        if (err) begin
            chk("err_fault", access_fault_out, 1);
            chk("err_novalid", lu_valid_out, 0);
            chk("err_stall", stall_out, 0);
            @(negedge clk_in);
            chk("err_fault_pulse", access_fault_out, 0);
        end else if (!we) begin
            chk("ld_valid", lu_valid_out, 1);
            chk("ld_data", lu_data_out, m_load(rdata, off, sz, uns));
            chk("ld_stall", stall_out, 1);
            chk("ld_nofault", access_fault_out, 0);
            @(negedge clk_in);
            chk("ld_valid_pulse", lu_valid_out, 0);
            chk("ld_stall_end", stall_out, 0);
        end else begin
            chk("st_novalid", lu_valid_out, 0);
            chk("st_stall", stall_out, 0);
            chk("st_nofault", access_fault_out, 0);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk_in);
        chk("rst_req", d_req_out, 0);
        chk("rst_stall", stall_out, 0);
        chk("rst_valid", lu_valid_out, 0);
        chk("rst_fault", access_fault_out, 0);
        chk("rst_data", lu_data_out, 0);
        chk("rst_mask", d_wr_mask_out, 0);
        rst_in = 0;

        txn(0, 2'b00, 0, 32'h1003, 0, 32'h80FF_1234, 0, 0);
        chk("lb_value", lu_data_out, 32'hFFFF_FF80);
        txn(0, 2'b01, 1, 32'h2002, 0, 32'hBEEF_0000, 3, 0);
        chk("lhu_value", lu_data_out, 32'h0000_BEEF);
        txn(1, 2'b00, 0, 32'h3001, 32'h0000_00A5, 0, 0, 0);
        chk("sb_wdata", d_wdata_out, 32'hA5A5_A5A5);
        chk("sb_mask", d_wr_mask_out, 4'b0010);
        txn(0, 2'b10, 0, 32'h4000, 0, 32'h1234_5678, 1, 1);

        // Misaligned store and trapped load never reach the bus.
        @(negedge clk_in);
        mem_wr_req_in = 1; load_size_in = 2'b10; iadder_in = 32'h5002; misaligned_store_in = 1;
        #1 chk("mis_stall", stall_out, 0);
        @(negedge clk_in);
        mem_wr_req_in = 0; misaligned_store_in = 0;
        chk("mis_req", d_req_out, 0);
        mem_rd_req_in = 1; iadder_in = 32'h5000; trap_taken_in = 1;
        #1 chk("trap_stall", stall_out, 0);
        @(negedge clk_in);
        mem_rd_req_in = 0; trap_taken_in = 0;
        chk("trap_req", d_req_out, 0);

        // Reset on the second BUSY cycle, then a stray ack.
        mem_rd_req_in = 1; load_size_in = 2'b10; iadder_in = 32'h6000;
        @(negedge clk_in);
        mem_rd_req_in = 0;
        chk("rb_busy1", d_req_out, 1);
        @(negedge clk_in);
        rst_in = 1;
        @(negedge clk_in);
        rst_in = 0;
        chk("rb_req", d_req_out, 0);
        chk("rb_stall", stall_out, 0);
        d_ack_in = 1; d_rdata_in = 32'hDEAD_BEEF;
        @(negedge clk_in);
        d_ack_in = 0;
        chk("rb_late_valid", lu_valid_out, 0);
        chk("rb_late_data", lu_data_out, 0);
        chk("rb_late_fault", access_fault_out, 0);
        txn(0, 2'b10, 0, 32'h6004, 0, 32'hCAFE_F00D, 1, 0);

`ifdef MSRV32_LSU_TIMEOUT_EN
        begin
            int n = 0;
            @(negedge clk_in);
            mem_rd_req_in = 1; load_size_in = 2'b10; iadder_in = 32'h7000;
            @(negedge clk_in);
            mem_rd_req_in = 0;
            while (d_req_out && n < 20) begin n++; @(negedge clk_in); end
            chk("to_cycles", n, TO);
            chk("to_fault", access_fault_out, 1);
            chk("to_novalid", lu_valid_out, 0);
        end
`endif

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  sz = 2'($urandom_range(0, 2));
            logic [31:0] a  = $urandom;
            if (sz == 2'b01) a[0] = 1'b0;
            if (sz == 2'b10) a[1:0] = 2'b00;
            txn(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 7) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
